// File: rtl/hood_mode_controller.sv
// Range-hood main sequencer: button pulses and a 1 Hz tick drive the 3-bit system state.
// Optional work-time clean reminder is built only when HOOD_CLEAN_REMINDER_EN is defined.
module hood_mode_controller #(
    parameter int unsigned THIRD_SECS  = 60,
    parameter int unsigned WAIT_SECS   = 60,
    parameter int unsigned CLEAN_SECS  = 180,
    parameter int unsigned REMIND_SECS = 36000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1s,
    input  logic       power_btn,
    input  logic       menu_btn,
    input  logic       lvl1_btn,
    input  logic       lvl2_btn,
    input  logic       lvl3_btn,
    input  logic       clean_btn,
    output logic [2:0] state,
    output logic [7:0] countdown,
    output logic       third_used,
    output logic       clean_reminder
);

    localparam logic [2:0] ST_OFF      = 3'b000;
    localparam logic [2:0] ST_STANDBY  = 3'b001;
    localparam logic [2:0] ST_MODE_SEL = 3'b010;
    localparam logic [2:0] ST_FIRST    = 3'b011;
    localparam logic [2:0] ST_SECOND   = 3'b100;
    localparam logic [2:0] ST_THIRD    = 3'b101;
    localparam logic [2:0] ST_CLEAN    = 3'b110;
    localparam logic [2:0] ST_WAIT     = 3'b111;

    localparam logic [7:0] THIRD_LD = 8'(THIRD_SECS);
    localparam logic [7:0] WAIT_LD  = 8'(WAIT_SECS);
    localparam logic [7:0] CLEAN_LD = 8'(CLEAN_SECS);

    if (THIRD_SECS < 1 || THIRD_SECS > 255) begin : g_bad_third
        $error("THIRD_SECS out of range 1..255");
    end
    if (WAIT_SECS < 1 || WAIT_SECS > 255) begin : g_bad_wait
        $error("WAIT_SECS out of range 1..255");
    end
    if (CLEAN_SECS < 1 || CLEAN_SECS > 255) begin : g_bad_clean
        $error("CLEAN_SECS out of range 1..255");
    end
    if (REMIND_SECS < 1 || REMIND_SECS > 65535) begin : g_bad_remind
        $error("REMIND_SECS out of range 1..65535");
    end

    logic [2:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       used_q, used_d;
    logic       clean_done;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        used_d     = used_q;
        clean_done = 1'b0;
        if (state_q == ST_OFF) begin
            if (power_btn) begin
                state_d = ST_STANDBY;
            end
        end else if (power_btn) begin
            state_d = ST_OFF;
            cnt_d   = 8'd0;
            used_d  = 1'b0;
        end else begin
            case (state_q)
                ST_STANDBY: begin
                    if (menu_btn) begin
                        state_d = ST_MODE_SEL;
                    end
                end
                ST_MODE_SEL, ST_FIRST, ST_SECOND: begin
                    // Self-clean is only selectable from MODE_SELECT; a blocked lvl3 falls through.
                    if (clean_btn && state_q == ST_MODE_SEL) begin
                        state_d = ST_CLEAN;
                        cnt_d   = CLEAN_LD;
                    end else if (lvl3_btn && !used_q) begin
                        state_d = ST_THIRD;
                        cnt_d   = THIRD_LD;
                        used_d  = 1'b1;
                    end else if (lvl2_btn) begin
                        state_d = ST_SECOND;
                    end else if (lvl1_btn) begin
                        state_d = ST_FIRST;
                    end else if (menu_btn) begin
                        state_d = ST_STANDBY;
                    end
                end
                ST_THIRD: begin
                    if (menu_btn) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LD;
                    end else if (tick_1s && cnt_q == 8'd1) begin
                        state_d = ST_SECOND;
                        cnt_d   = 8'd0;
                    end else if (tick_1s && cnt_q != 8'd0) begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                ST_WAIT, ST_CLEAN: begin
                    if (tick_1s && cnt_q == 8'd1) begin
                        state_d    = ST_STANDBY;
                        cnt_d      = 8'd0;
                        clean_done = (state_q == ST_CLEAN);
                    end else if (tick_1s && cnt_q != 8'd0) begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_OFF;
            cnt_q   <= 8'd0;
            used_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            used_q  <= used_d;
        end
    end

    assign state      = state_q;
    assign countdown  = cnt_q;
    assign third_used = used_q;

`ifdef HOOD_CLEAN_REMINDER_EN
    localparam logic [15:0] REMIND_LD = 16'(REMIND_SECS);

    logic [15:0] work_q, work_d;
    logic        remind_q, remind_d;
    logic        working;

    assign working = (state_q == ST_FIRST) || (state_q == ST_SECOND) || (state_q == ST_THIRD);

    // Survives power-off; only reset or a completed self-clean clears it.
    always_comb begin
        work_d = work_q;
        if (clean_done) begin
            work_d = 16'd0;
        end else if (tick_1s && !power_btn && working && work_q != REMIND_LD) begin
            work_d = work_q + 16'd1;
        end
        remind_d = (work_d == REMIND_LD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            work_q   <= 16'd0;
            remind_q <= 1'b0;
        end else begin
            work_q   <= work_d;
            remind_q <= remind_d;
        end
    end

    assign clean_reminder = remind_q;
`else
    assign clean_reminder = 1'b0;
`endif

endmodule

// File: tb/tb_hood_mode_controller.sv
// Directed self-checking bench for hood_mode_controller (short timers, REMIND_SECS=3).
module tb_hood_mode_controller;

    localparam logic [6:0] TK = 7'h40;
    localparam logic [6:0] PW = 7'h20;
    localparam logic [6:0] MN = 7'h10;
    localparam logic [6:0] L1 = 7'h08;
    localparam logic [6:0] L2 = 7'h04;
    localparam logic [6:0] L3 = 7'h02;
    localparam logic [6:0] CL = 7'h01;

`ifdef HOOD_CLEAN_REMINDER_EN
    localparam logic REM_ON = 1'b1;
`else
    localparam logic REM_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_1s = 1'b0, power_btn = 1'b0, menu_btn = 1'b0;
    logic       lvl1_btn = 1'b0, lvl2_btn = 1'b0, lvl3_btn = 1'b0, clean_btn = 1'b0;
    logic [2:0] state;
    logic [7:0] countdown;
    logic       third_used;
    logic       clean_reminder;

    int total = 0;
    int bad   = 0;

    hood_mode_controller #(
        .THIRD_SECS (5),
        .WAIT_SECS  (45),
        .CLEAN_SECS (4),
        .REMIND_SECS(3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tick_1s       (tick_1s),
        .power_btn     (power_btn),
        .menu_btn      (menu_btn),
        .lvl1_btn      (lvl1_btn),
        .lvl2_btn      (lvl2_btn),
        .lvl3_btn      (lvl3_btn),
        .clean_btn     (clean_btn),
        .state         (state),
        .countdown     (countdown),
        .third_used    (third_used),
        .clean_reminder(clean_reminder)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_sc(input string tag, input logic [2:0] st, input logic [7:0] cd);
        chk({tag, ".state"}, 16'(state), 16'(st));
        chk({tag, ".countdown"}, 16'(countdown), 16'(cd));
    endtask

    // Drive one cycle of button/tick pulses, then sample just after the edge.
    task automatic cyc(input logic [6:0] b);
        {tick_1s, power_btn, menu_btn, lvl1_btn, lvl2_btn, lvl3_btn, clean_btn} = b;
        @(posedge clk);
        #1;
        {tick_1s, power_btn, menu_btn, lvl1_btn, lvl2_btn, lvl3_btn, clean_btn} = 7'h00;
    endtask

    initial begin
        rst = 1'b1;
        cyc(7'h00);
        cyc(PW | MN);
        rst = 1'b0;
        chk_sc("reset", 3'd0, 8'd0);
        chk("reset.used", 16'(third_used), 16'd0);
        chk("reset.rem", 16'(clean_reminder), 16'd0);

        cyc(MN);        chk_sc("off_ignores", 3'd0, 8'd0);
        cyc(PW);        chk_sc("pwr_on", 3'd1, 8'd0);
        cyc(MN);        chk_sc("menu", 3'd2, 8'd0);
        cyc(L2);        chk_sc("lvl2", 3'd4, 8'd0);
        cyc(L1);        chk_sc("lvl1", 3'd3, 8'd0);
        cyc(CL);        chk_sc("lvl1_clean_ign", 3'd3, 8'd0);
        cyc(MN);        chk_sc("lvl_menu", 3'd1, 8'd0);

        cyc(MN);
        cyc(L3 | L2 | L1); chk_sc("sel_prio_l3", 3'd5, 8'd5);
        chk("l3.used", 16'(third_used), 16'd1);
        cyc(TK);        chk_sc("third_t1", 3'd5, 8'd4);
        cyc(TK);        chk_sc("third_t2", 3'd5, 8'd3);
        cyc(L1 | CL);   chk_sc("third_btn_ign", 3'd5, 8'd3);
        cyc(TK);        chk_sc("third_t3", 3'd5, 8'd2);
        cyc(TK);        chk_sc("third_t4", 3'd5, 8'd1);
        cyc(TK);        chk_sc("third_expire", 3'd4, 8'd0);
        cyc(L3);        chk_sc("l3_reuse_blocked", 3'd4, 8'd0);
        chk("reuse.used", 16'(third_used), 16'd1);

        cyc(PW);        chk_sc("pwr_off", 3'd0, 8'd0);
        chk("off.used", 16'(third_used), 16'd0);
        cyc(PW);
        cyc(MN);
        cyc(L3);
        cyc(TK);
        cyc(TK);        chk_sc("third_at3", 3'd5, 8'd3);
        cyc(MN | TK);   chk_sc("wait_load", 3'd7, 8'd45);
        cyc(MN | L3 | CL); chk_sc("wait_btn_ign", 3'd7, 8'd45);
        for (int i = 0; i < 44; i++) cyc(TK);
        chk_sc("wait_last", 3'd7, 8'd1);
        cyc(TK);        chk_sc("wait_expire", 3'd1, 8'd0);

        cyc(MN);
        cyc(CL | L3);   chk_sc("sel_prio_clean", 3'd6, 8'd4);
        cyc(TK);
        cyc(TK);        chk_sc("clean_at2", 3'd6, 8'd2);
        cyc(PW | TK);   chk_sc("clean_pwr", 3'd0, 8'd0);
        chk("clean_pwr.used", 16'(third_used), 16'd0);
        cyc(PW);
        cyc(MN);
        cyc(L3);        chk_sc("l3_after_cycle", 3'd5, 8'd5);
        chk("cycle.used", 16'(third_used), 16'd1);

        rst = 1'b1;
        cyc(7'h00);
        rst = 1'b0;
        cyc(PW);
        cyc(MN);
        cyc(L1);
        cyc(TK);
        cyc(TK);        chk("rem_2s", 16'(clean_reminder), 16'd0);
        cyc(TK);        chk("rem_3s", 16'(clean_reminder), 16'(REM_ON));
        cyc(TK);        chk("rem_sat", 16'(clean_reminder), 16'(REM_ON));
        cyc(PW);        chk("rem_off", 16'(clean_reminder), 16'(REM_ON));
        cyc(PW);        chk("rem_on", 16'(clean_reminder), 16'(REM_ON));
        cyc(MN);
        cyc(CL);
        cyc(TK);
        cyc(TK);
        cyc(TK);        chk("rem_mid_clean", 16'(clean_reminder), 16'(REM_ON));
        cyc(TK);        chk_sc("clean_done", 3'd1, 8'd0);
        chk("rem_cleared", 16'(clean_reminder), 16'd0);

        cyc(MN);
        cyc(L1);
        cyc(TK);
        cyc(TK);
        cyc(TK);        chk("rem_again", 16'(clean_reminder), 16'(REM_ON));
        cyc(L3);
        cyc(MN);
        for (int i = 0; i < 5; i++) cyc(TK);
        chk_sc("wait_at40", 3'd7, 8'd40);
        rst = 1'b1;
        cyc(PW | TK);
        rst = 1'b0;
        chk_sc("rst_mid_wait", 3'd0, 8'd0);
        chk("rst.used", 16'(third_used), 16'd0);
        chk("rst.rem", 16'(clean_reminder), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
